// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: divisor/enable inputs and tick outputs of the UART baud generator
interface uart_baud_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic [DIV_W-1:0]  baud_div;
    logic [FRAC_W-1:0] baud_frac;
    logic              tx_en;
    logic              rx_en;
    logic              rx_sync;
    logic              os_tick;
    logic              tx_tick;
    logic              rx_sample;
    logic              cfg_err;
    modport master (
        output baud_div, baud_frac, tx_en, rx_en, rx_sync,
        input  os_tick, tx_tick, rx_sample, cfg_err
    );
    modport slave (
        input  baud_div, baud_frac, tx_en, rx_en, rx_sync,
        output os_tick, tx_tick, rx_sample, cfg_err
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional oversample prescaler with independent TX bit and RX mid-bit phase counters
module uart_baud_gen #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR    = 16
) (
    input logic           clk,
    input logic           rst_x,
    uart_baud_gen_if.slave bus
);
    localparam int OS_W = $clog2(OSR);
    logic              run;
    logic              bad_div;
    logic              os_tick;
    logic              cfg_err;
    logic              extra;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  pre_cnt;
    logic [DIV_W-1:0]  lim;
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic [OS_W-1:0]   tx_os;
    logic [OS_W-1:0]   rx_os;
    assign run     = bus.tx_en | bus.rx_en;
    assign bad_div = div_q < DIV_W'(2);
    assign lim     = div_q - DIV_W'(1) + {{(DIV_W-1){1'b0}}, extra};
    assign acc_sum = {1'b0, acc} + {1'b0, frac_q};
    // bad_div also gates the very first enabled cycle, before cfg_err has registered
    assign os_tick       = run & ~cfg_err & ~bad_div & (pre_cnt == lim);
    assign bus.os_tick   = os_tick;
    assign bus.tx_tick   = os_tick & bus.tx_en & (tx_os == OS_W'(OSR - 1));
    assign bus.rx_sample = os_tick & bus.rx_en & ~bus.rx_sync & (rx_os == OS_W'(OSR / 2 - 1));
    assign bus.cfg_err   = cfg_err;
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            div_q   <= '0;
            frac_q  <= '0;
            pre_cnt <= '0;
            acc     <= '0;
            extra   <= 1'b0;
            cfg_err <= 1'b0;
            tx_os   <= '0;
            rx_os   <= '0;
        end else begin
            cfg_err <= run & bad_div;
            if (!run) begin
                div_q   <= bus.baud_div;
                frac_q  <= bus.baud_frac;
                pre_cnt <= '0;
                acc     <= '0;
                extra   <= 1'b0;
            end else if (os_tick) begin
                pre_cnt <= '0;
                acc     <= acc_sum[FRAC_W-1:0];
                extra   <= acc_sum[FRAC_W];
            end else if (!bad_div) begin
                pre_cnt <= pre_cnt + DIV_W'(1);
            end
            tx_os <= !bus.tx_en ? '0 : os_tick ? tx_os + OS_W'(1) : tx_os;
            rx_os <= (!bus.rx_en || bus.rx_sync) ? '0 : os_tick ? rx_os + OS_W'(1) : rx_os;
        end
    end
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed vectors for the baud generator, OSR=4 and OSR=16 instances driven in parallel
module tb_uart_baud_gen;
    logic        clk = 1'b0;
    logic        rst_x = 1'b1;
    logic [15:0] baud_div = '0;
    logic [3:0]  baud_frac = '0;
    logic        tx_en = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx_sync = 1'b0;
    int total = 0;
    int bad = 0;
    int m_first, m_cyc, m_tx4, m_tx16, m_tx4_first, m_tx4_last, m_rx;
    typedef struct {
        logic [15:0] div;
        logic [3:0]  frac;
        int          n;
        int          first;
        int          cycles;
        int          tx1;
    } vec_t;
    vec_t tbl[6];
    always #5 clk = ~clk;
    uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) b4 ();
    uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) b16 ();
    assign b4.baud_div   = baud_div;
    assign b4.baud_frac  = baud_frac;
    assign b4.tx_en      = tx_en;
    assign b4.rx_en      = rx_en;
    assign b4.rx_sync    = rx_sync;
    assign b16.baud_div  = baud_div;
    assign b16.baud_frac = baud_frac;
    assign b16.tx_en     = tx_en;
    assign b16.rx_en     = rx_en;
    assign b16.rx_sync   = rx_sync;
    uart_baud_gen #(.DIV_W(16), .FRAC_W(4), .OSR(4)) dut4 (.clk(clk), .rst_x(rst_x), .bus(b4));
    uart_baud_gen #(.DIV_W(16), .FRAC_W(4), .OSR(16)) dut16 (.clk(clk), .rst_x(rst_x), .bus(b16));
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask
    task automatic outs0(input string nm);
        chk(nm, {24'd0, b4.os_tick, b4.tx_tick, b4.rx_sample, b4.cfg_err,
                 b16.os_tick, b16.tx_tick, b16.rx_sample, b16.cfg_err}, 32'd0);
    endtask
    // Starts and ends on a falling edge; counts enabled cycles until n os_ticks are seen.
    task automatic measure(input int n);
        int got;
        got = 0;
        m_first = 0; m_cyc = 0; m_tx4 = 0; m_tx16 = 0; m_tx4_first = 0; m_tx4_last = 0; m_rx = 0;
        while (got < n && m_cyc < n * 10 + 20) begin
            #1;
            m_cyc++;
            if (b4.os_tick) begin
                got++;
                if (got == 1) m_first = m_cyc;
            end
            if (b4.tx_tick) begin
                m_tx4++;
                if (m_tx4 == 1) m_tx4_first = m_cyc;
                m_tx4_last = m_cyc;
            end
            if (b16.tx_tick) m_tx16++;
            if (b4.rx_sample) m_rx++;
            @(negedge clk);
        end
        chk("tick_count", got, n);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int cnt, txc;
        logic exp_os, exp_s16, exp_s4, exp_tx;
        tbl[0] = '{16'd4, 4'd0,  16, 4, 64,  16};
        tbl[1] = '{16'd4, 4'd8,  32, 4, 143, 17};
        tbl[2] = '{16'd3, 4'd4,  8,  3, 25,  12};
        tbl[3] = '{16'd5, 4'd15, 16, 5, 94,  22};
        tbl[4] = '{16'd2, 4'd0,  8,  2, 16,  8};
        tbl[5] = '{16'd7, 4'd0,  4,  7, 28,  28};
        #1 rst_x = 1'b0;
        #2 outs0("reset_outputs");
        @(negedge clk);
        rst_x = 1'b1;
        @(negedge clk);
        #1 outs0("idle_outputs");
        @(negedge clk);
        foreach (tbl[i]) begin
            tx_en = 1'b0; rx_en = 1'b0;
            baud_div = tbl[i].div; baud_frac = tbl[i].frac;
            @(negedge clk);
            tx_en = 1'b1;
            measure(tbl[i].n);
            chk($sformatf("row%0d_first", i), m_first, tbl[i].first);
            chk($sformatf("row%0d_cycles", i), m_cyc, tbl[i].cycles);
            chk($sformatf("row%0d_tx4_count", i), m_tx4, tbl[i].n / 4);
            chk($sformatf("row%0d_tx4_first", i), m_tx4_first, tbl[i].tx1);
            chk($sformatf("row%0d_tx4_last", i), m_tx4_last, tbl[i].cycles);
            chk($sformatf("row%0d_tx16_count", i), m_tx16, tbl[i].n / 16);
            chk($sformatf("row%0d_rx_quiet", i), m_rx, 0);
        end
        // RX phase: syncs at 5, 29 (mid-bit) and 44 (on a tick that would sample); TX toggled meanwhile
        tx_en = 1'b0; rx_en = 1'b0; baud_div = 16'd2; baud_frac = 4'd0;
        @(negedge clk);
        rx_en = 1'b1;
        cnt = 0; txc = 0;
        for (int c = 1; c <= 100; c++) begin
            rx_sync = (c == 5 || c == 29 || c == 44);
            tx_en = (c >= 50 && c < 70);
            exp_os = (c % 2 == 0);
            if (rx_sync) begin
                cnt = 0; exp_s16 = 1'b0; exp_s4 = 1'b0;
            end else begin
                if (exp_os) cnt++;
                exp_s16 = exp_os && (cnt % 16 == 8);
                exp_s4 = exp_os && (cnt % 4 == 2);
            end
            if (!tx_en) txc = 0;
            else if (exp_os) txc++;
            exp_tx = exp_os && tx_en && (txc % 4 == 0);
            #1;
            chk($sformatf("rx_os_tick_c%0d", c), b16.os_tick, exp_os);
            chk($sformatf("rx_sample16_c%0d", c), b16.rx_sample, exp_s16);
            chk($sformatf("rx_sample4_c%0d", c), b4.rx_sample, exp_s4);
            chk($sformatf("tx_tick4_c%0d", c), b4.tx_tick, exp_tx);
            @(negedge clk);
        end
        rx_sync = 1'b0; tx_en = 1'b0; rx_en = 1'b0;
        // divisor change while running is deferred until both enables drop
        baud_div = 16'd4;
        @(negedge clk);
        tx_en = 1'b1;
        measure(2);
        chk("hold_first", m_first, 4);
        chk("hold_two_ticks", m_cyc, 8);
        baud_div = 16'd6;
        measure(1);
        chk("hold_period_a", m_cyc, 4);
        measure(1);
        chk("hold_period_b", m_cyc, 4);
        tx_en = 1'b0;
        @(negedge clk);
        tx_en = 1'b1;
        measure(1);
        chk("reload_first", m_cyc, 6);
        measure(1);
        chk("reload_period", m_cyc, 6);
        // illegal divisors
        tx_en = 1'b0; baud_div = 16'd1;
        @(negedge clk);
        tx_en = 1'b1;
        #1;
        chk("div1_err_first_cycle", b4.cfg_err, 0);
        chk("div1_tick_first_cycle", b4.os_tick, 0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("div1_cfg_err", b4.cfg_err, 1);
            chk("div1_no_ticks", {b4.os_tick, b4.tx_tick, b16.tx_tick}, 0);
            @(negedge clk);
        end
        tx_en = 1'b0;
        @(negedge clk);
        #1 chk("div1_err_clear", b4.cfg_err, 0);
        @(negedge clk);
        baud_div = 16'd0;
        @(negedge clk);
        tx_en = 1'b1;
        @(negedge clk);
        #1;
        chk("div0_cfg_err", b16.cfg_err, 1);
        chk("div0_no_tick", b16.os_tick, 0);
        @(negedge clk);
        tx_en = 1'b0;
        @(negedge clk);
        // reset mid-bit with both enables high
        baud_div = 16'd4;
        @(negedge clk);
        tx_en = 1'b1; rx_en = 1'b1;
        repeat (7) @(negedge clk);
        #1 chk("pre_reset_tick", {b4.os_tick, b4.rx_sample}, 2'b11);
        #1 rst_x = 1'b0;
        #1 outs0("reset_mid_bit");
        @(negedge clk);
        #1 outs0("reset_held");
        rst_x = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_cfg_err", b4.cfg_err, 1);
        chk("post_reset_no_tick", b4.os_tick, 0);
        @(negedge clk);
        tx_en = 1'b0; rx_en = 1'b0;
        @(negedge clk);
        tx_en = 1'b1; rx_en = 1'b1;
        measure(4);
        chk("post_reset_first", m_first, 4);
        chk("post_reset_cycles", m_cyc, 16);
        chk("post_reset_tx4", m_tx4_first, 16);
        chk("post_reset_rx4", m_rx, 1);
        tx_en = 1'b0; rx_en = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the integer baud divisor.
REQ-002 SHALL have parameter FRAC_W, default 4: width of the fractional divisor, in units of 1/2^FRAC_W cycle.
REQ-003 SHALL have parameter OSR, default 16: oversample ratio; legal values are powers of 2 that are at least 4.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst_x, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port baud_div, input, DIV_W: integer divisor, in clk cycles per oversample tick.
REQ-007 SHALL have port baud_frac, input, FRAC_W: fractional divisor addend.
REQ-008 SHALL have port tx_en, input, 1: TX bit timing enable, active high.
REQ-009 SHALL have port rx_en, input, 1: RX bit timing enable, active high.
REQ-010 SHALL have port rx_sync, input, 1: single-cycle pulse on start-bit detect that restarts the RX phase.
REQ-011 SHALL have port os_tick, output, 1: oversample tick, one cycle wide.
REQ-012 SHALL have port tx_tick, output, 1: TX bit boundary, one cycle wide.
REQ-013 SHALL have port rx_sample, output, 1: RX mid-bit sample strobe, one cycle wide.
REQ-014 SHALL have port cfg_err, output, 1: the latched divisor is illegal.

Function
REQ-015 SHALL define run = tx_en | rx_en.
REQ-016 SHALL load div_q and frac_q from baud_div and baud_frac on every cycle in which run=0.
REQ-017 SHALL hold div_q and frac_q while run=1; input changes take effect only after both enables have gone low.
REQ-018 SHALL hold prescaler pre_cnt and accumulator acc at 0 while run=0.
REQ-019 SHALL increment pre_cnt each cycle while run=1, with limit lim = div_q-1+extra.
REQ-020 SHALL assert os_tick combinationally when run=1, cfg_err=0 and pre_cnt==lim; on that cycle pre_cnt SHALL return to 0.
REQ-021 SHALL update acc <= acc+frac_q (modulo 2^FRAC_W) on each os_tick, register the carry-out as extra for the next period, and reset extra to 0 while run=0.
REQ-022 SHALL therefore produce a mean os_tick period of div_q + frac_q/2^FRAC_W cycles, with each individual period equal to div_q or div_q+1.
REQ-023 SHALL assert the first os_tick in the div_q-th enabled cycle, where the first cycle with run=1 has pre_cnt=0.
REQ-024 SHALL set cfg_err as a registered flag, 1 the cycle after run=1 with div_q<2, holding pre_cnt at 0 with no ticks, and clearing it when run=0.
REQ-025 SHALL keep a TX phase counter tx_os (log2(OSR) bits) that increments on os_tick while tx_en=1, wraps from OSR-1 to 0, and is 0 while tx_en=0.
REQ-026 SHALL assert tx_tick = os_tick & tx_en & (tx_os==OSR-1), giving OSR os_ticks per bit.
REQ-027 SHALL keep an RX phase counter rx_os that increments on os_tick while rx_en=1, wraps at OSR-1, and is 0 while rx_en=0.
REQ-028 SHALL set rx_os to 0 on rx_sync when rx_en=1; if rx_sync and os_tick coincide, rx_sync wins, rx_os=0 and no rx_sample is issued that cycle.
REQ-029 SHALL assert rx_sample = os_tick & rx_en & ~rx_sync & (rx_os==OSR/2-1), i.e. on the (OSR/2)-th os_tick after rx_sync and every OSR os_ticks thereafter.
REQ-030 SHALL ignore rx_sync while rx_en=0.
REQ-031 SHALL keep TX and RX phases independent and sharing the prescaler; toggling one enable SHALL NOT disturb the other's counter while run stays 1.
REQ-032 SHALL ensure that at most one pulse of each tick output occurs per os_tick, with no pulse on any output while cfg_err=1.

Reset
REQ-033 SHALL on rst_x=0 asynchronously clear pre_cnt, acc, extra, tx_os, rx_os, div_q, frac_q and cfg_err, driving os_tick, tx_tick, rx_sample and cfg_err to 0.
REQ-034 SHALL, after reset release with an enable already high, leave div_q=0, so cfg_err sets until run drops; software SHALL deassert enables across reset.
REQ-035 SHALL, on reset during operation, abort mid-bit timing with no residual pulse; the first post-reset tick SHALL obey REQ-023.

Verification
REQ-036 SHALL check: OSR=4, baud_div=4, baud_frac=0, tx_en rise -> os_tick at enabled cycles 4, 8, 12, 16; tx_tick only at cycle 16, then every 16.
REQ-037 SHALL check: baud_div=4, baud_frac=8 (FRAC_W=4) -> os_tick periods 4, 4, 5, 4, 5, ..., averaging 4.5 over 32 ticks.
REQ-038 SHALL check: OSR=16, baud_div=2, rx_en=1, rx_sync pulse -> rx_sample on the 8th os_tick after it, then every 16th; a second rx_sync mid-bit restarts at 8; rx_sync coincident with os_tick gives no rx_sample.
REQ-039 SHALL check: baud_div changed from 4 to 6 while tx_en=1 -> period stays 4; drop both enables for 1 cycle and re-enable -> period 6.
REQ-040 SHALL check: baud_div=1 with tx_en=1 -> cfg_err=1 from the next cycle, no ticks; tx_en=0 -> cfg_err=0.
REQ-041 SHALL check: rst_x pulsed low mid-bit with tx_en and rx_en high -> all outputs 0 immediately and counters 0; after release, with enables cycled, first os_tick follows REQ-023.
